// File: rtl/semafor_inel_if.sv
// rtl/semafor_inel_if.sv - lamp, direction and request signals of the semafor_inel ring controller
interface semafor_inel_if #(
    parameter int NUM_DIR = 4
);
    localparam int DW = $clog2(NUM_DIR);

    logic               intretinere;
    logic [NUM_DIR-1:0] cerere;
    logic [NUM_DIR-1:0] verde;
    logic [NUM_DIR-1:0] galben;
    logic [NUM_DIR-1:0] rosu;
    logic [DW-1:0]      dir_activ;
    logic               ciclu_done;

    modport master (
        output intretinere, cerere,
        input  verde, galben, rosu, dir_activ, ciclu_done
    );

    modport slave (
        input  intretinere, cerere,
        output verde, galben, rosu, dir_activ, ciclu_done
    );
endinterface

// File: rtl/semafor_inel.sv
// rtl/semafor_inel.sv - round-robin traffic light ring controller for NUM_DIR approaches
// Optional demand-based skipping of idle approaches: define SEMAFOR_SKIP_EN.
module semafor_inel #(
    parameter int TICK_DIV = 10000000,
    parameter int NUM_DIR  = 4,
    parameter int T_ALLRED = 1,
    parameter int T_PREP   = 2,
    parameter int T_GREEN  = 29,
    parameter int T_YEL    = 3
) (
    input  logic           clk,
    input  logic           reset,
    semafor_inel_if.slave  bus
);
    localparam int DW   = $clog2(NUM_DIR);
    localparam int TM1  = (T_ALLRED > T_PREP) ? T_ALLRED : T_PREP;
    localparam int TM2  = (T_GREEN > T_YEL) ? T_GREEN : T_YEL;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CW   = $clog2(TMAX) + 1;
    localparam int PW   = $clog2(TICK_DIV) + 1;

    typedef enum logic [2:0] {ALLRED, PREP, GREEN, YEL, MAINT} state_t;

    state_t             state, n_state;
    logic [DW-1:0]      dir, n_dir, dir_inc, adv_dir;
    logic [PW-1:0]      pre, n_pre;
    logic [CW-1:0]      cnt, n_cnt, cnt_last;
    logic               first, n_first;
    logic               flash, n_flash;
    logic               tick, adv_ok, n_done;
    logic [NUM_DIR-1:0] n_verde, n_galben, n_rosu;
    logic [NUM_DIR-1:0] verde_q, galben_q, rosu_q;
    logic               done_q;

    assign tick    = (pre == PW'(TICK_DIV - 1));
    assign dir_inc = (dir == DW'(NUM_DIR - 1)) ? '0 : dir + DW'(1);

    always_comb begin
        cnt_last = '0;
        case (state)
            ALLRED:  cnt_last = CW'(T_ALLRED - 1);
            PREP:    cnt_last = CW'(T_PREP - 1);
            GREEN:   cnt_last = CW'(T_GREEN - 1);
            YEL:     cnt_last = CW'(T_YEL - 1);
            default: cnt_last = '0;
        endcase
    end

`ifdef SEMAFOR_SKIP_EN
    // Candidates are scanned from dir+1 onward, so the current dir comes last
    // and only wins when nobody else asks; after reset/MAINT the scan starts at 0.
    always_comb begin : p_search
        int cand;
        cand    = 0;
        adv_ok  = 1'b0;
        adv_dir = dir;
        for (int k = 0; k < NUM_DIR; k++) begin
            cand = first ? k : (int'(dir) + 1 + k) % NUM_DIR;
            if (!adv_ok && ((bus.cerere >> cand) & NUM_DIR'(1)) != '0) begin
                adv_ok  = 1'b1;
                adv_dir = DW'(cand);
            end
        end
    end
`else
    logic unused_cerere;
    assign unused_cerere = ^bus.cerere;
    assign adv_ok        = 1'b1;
    assign adv_dir       = first ? '0 : dir_inc;
`endif

    always_comb begin
        n_state = state;
        n_dir   = dir;
        n_first = first;
        n_flash = flash;
        n_cnt   = cnt;
        n_pre   = tick ? '0 : pre + PW'(1);
        n_done  = 1'b0;
        if (bus.intretinere) begin
            if (state != MAINT) begin
                n_state = MAINT;
                n_cnt   = '0;
                n_flash = 1'b0;
            end else if (tick) begin
                n_flash = ~flash;
            end
        end else if (state == MAINT) begin
            // Leaving maintenance restarts a complete, aligned cycle from approach 0.
            n_state = ALLRED;
            n_dir   = '0;
            n_pre   = '0;
            n_cnt   = '0;
            n_first = 1'b1;
            n_flash = 1'b0;
        end else if (tick) begin
            if (cnt != cnt_last) begin
                n_cnt = cnt + CW'(1);
            end else begin
                n_cnt = '0;
                case (state)
                    ALLRED: begin
                        if (adv_ok) begin
                            n_state = PREP;
                            n_dir   = adv_dir;
                            n_first = 1'b0;
                        end
                    end
                    PREP:  n_state = GREEN;
                    GREEN: n_state = YEL;
                    YEL: begin
                        n_state = ALLRED;
                        n_done  = (dir == DW'(NUM_DIR - 1));
                    end
                    default: n_state = ALLRED;
                endcase
            end
        end
    end

    // Lamps are decoded from the next state so they switch on the same edge as the FSM.
    always_comb begin
        n_verde  = '0;
        n_galben = '0;
        n_rosu   = '1;
        if (n_state == MAINT) begin
            n_rosu   = '0;
            n_galben = {NUM_DIR{n_flash}};
        end else begin
            for (int i = 0; i < NUM_DIR; i++) begin
                if (DW'(i) == n_dir) begin
                    if (n_state == PREP || n_state == YEL) begin
                        n_galben[i] = 1'b1;
                        n_rosu[i]   = 1'b0;
                    end else if (n_state == GREEN) begin
                        n_verde[i] = 1'b1;
                        n_rosu[i]  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ALLRED;
            dir      <= '0;
            pre      <= '0;
            cnt      <= '0;
            first    <= 1'b1;
            flash    <= 1'b0;
            verde_q  <= '0;
            galben_q <= '0;
            rosu_q   <= '1;
            done_q   <= 1'b0;
        end else begin
            state    <= n_state;
            dir      <= n_dir;
            pre      <= n_pre;
            cnt      <= n_cnt;
            first    <= n_first;
            flash    <= n_flash;
            verde_q  <= n_verde;
            galben_q <= n_galben;
            rosu_q   <= n_rosu;
            done_q   <= n_done;
        end
    end

    assign bus.verde      = verde_q;
    assign bus.galben     = galben_q;
    assign bus.rosu       = rosu_q;
    assign bus.dir_activ  = dir;
    assign bus.ciclu_done = done_q;
endmodule
